// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and helpers for the execute-stage ALU.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = $clog2(XLEN);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  // One-bit shift step; SRA replicates the sign bit.
  function automatic logic [XLEN-1:0] shift_one(input logic [3:0] code,
                                                input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    case (code)
      ALU_SLL: r = {v[XLEN-2:0], 1'b0};
      ALU_SRL: r = {1'b0, v[XLEN-1:1]};
      ALU_SRA: r = {v[XLEN-1], v[XLEN-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter_iter.sv
// Iterative one-bit-per-cycle shifter. The first step is applied on load,
// so a shift of N takes N edges in total counting the load edge.
module alu_shifter_iter
  import alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [3:0]      code_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [SHW-1:0]  shamt_i,
  output logic [XLEN-1:0] first_o,
  output logic [XLEN-1:0] next_o,
  output logic            last_o
);

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      code_q, code_d;

  assign first_o = shift_one(code_i, data_i);
  assign next_o  = shift_one(code_q, work_q);
  assign last_o  = (cnt_q == CNT_ONE);

  // Next-state for working register, remaining-step counter and op kind.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    code_d = code_q;
    if (load_i) begin
      work_d = first_o;
      cnt_d  = shamt_i - CNT_ONE;
      code_d = code_i;
    end else if (step_i) begin
      work_d = next_o;
      cnt_d  = cnt_q - CNT_ONE;
    end else begin
      work_d = work_q;
    end
  end

  // Shifter state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      work_q <= {XLEN{1'b0}};
      cnt_q  <= {SHW{1'b0}};
      code_q <= 4'b0000;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      code_q <= code_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative shifts,
// valid/ready on both sides and registered result/zero/illegal.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [SHW-1:0] SHAMT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] alu_res_s;
  logic            alu_ill_s;
  logic [SHW-1:0]  shamt_s;
  logic            accept_s;
  logic            shift_long_s;
  logic            sh_load_s;
  logic            sh_step_s;
  logic [XLEN-1:0] sh_first_s;
  logic [XLEN-1:0] sh_next_s;
  logic            sh_last_s;

  assign shamt_s      = op_b[SHW-1:0];
  // Ready depends only on state, out_ready and reset, never on in_valid.
  assign in_ready     = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept_s     = in_valid && in_ready;
  assign shift_long_s = is_shift(alu_control) && (shamt_s > SHAMT_ONE);

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  alu_shifter_iter u_shifter (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (sh_load_s),
    .step_i  (sh_step_s),
    .code_i  (alu_control),
    .data_i  (op_a),
    .shamt_i (shamt_s),
    .first_o (sh_first_s),
    .next_o  (sh_next_s),
    .last_o  (sh_last_s)
  );

  // Single-cycle datapath; shifts of 0 or 1 finish here without iterating.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    alu_ill_s = 1'b0;
    case (alu_control)
      ALU_AND:  alu_res_s = op_a & op_b;
      ALU_OR:   alu_res_s = op_a | op_b;
      ALU_ADD:  alu_res_s = op_a + op_b;
      ALU_SUB:  alu_res_s = op_a - op_b;
      ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_res_s = op_a ^ op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        if (shamt_s == {SHW{1'b0}}) begin
          alu_res_s = op_a;
        end else begin
          alu_res_s = sh_first_s;
        end
      end
      default: begin
        alu_res_s = {XLEN{1'b0}};
        alu_ill_s = 1'b1;
      end
    endcase
  end

  // FSM next state and output-register next values.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    sh_load_s = 1'b0;
    sh_step_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (shift_long_s) begin
            sh_load_s = 1'b1;
            state_d   = S_SHIFT;
          end else begin
            state_d   = S_DONE;
            result_d  = alu_res_s;
            zero_d    = (alu_res_s == {XLEN{1'b0}});
            illegal_d = alu_ill_s;
          end
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_SHIFT: begin
        sh_step_s = 1'b1;
        if (sh_last_s) begin
          state_d   = S_DONE;
          result_d  = sh_next_s;
          zero_d    = (sh_next_s == {XLEN{1'b0}});
          illegal_d = 1'b0;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      result_q  <= {XLEN{1'b0}};
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expectations, a
// monitor on the falling edge compares each presented result.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  alu_exec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
  } vec_t;

  exp_t sb[$];
  exp_t head;
  bit   head_seen = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one op, wait (bounded) for acceptance, optionally push its expectation.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez, input logic ei,
                       input int lat, input bit push, output int acc);
    int   budget;
    exp_t e;
    budget = 0;
    while (in_ready !== 1'b1 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 100) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got %b expected 1", in_ready);
    end
    alu_control = c;
    op_a        = a;
    op_b        = b;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    acc   = cyc;
    e.res = er;
    e.zero = ez;
    e.ill = ei;
    e.lat = lat;
    e.acc = acc;
    if (push) sb.push_back(e);
    in_valid    = 1'b0;
    op_a        = $urandom;
    op_b        = $urandom;
    alu_control = 4'($urandom);
  endtask

  // Monitor: compare whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got result %h with no op outstanding", result);
      end else begin
        head = sb[0];
        if (!head_seen) begin
          chk("latency", 32'(cyc - head.acc + 1), 32'(head.lat));
          head_seen = 1'b1;
        end
        chk("result", result, head.res);
        chk("zero", {31'b0, zero}, {31'b0, head.zero});
        chk("illegal", {31'b0, illegal}, {31'b0, head.ill});
        if (out_ready === 1'b1) begin
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t vt[6];
  int   a1, a2, ax, ab, tmp;

  initial begin
    vt[0] = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vt[1] = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vt[2] = '{ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0};
    vt[3] = '{ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0};
    vt[4] = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vt[5] = '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = 4'b0000; op_a = 32'h0; op_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h0);
    chk("rst_illegal", {31'b0, illegal}, 32'h0);
    chk("rst_in_ready_low", {31'b0, in_ready}, 32'h0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_release", {31'b0, in_ready}, 32'h1);

    // ADD overflow wrap, then SUB to zero back-to-back.
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1, 1'b1, a1);
    issue(ALU_SUB, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0, 1, 1'b1, a2);
    chk("no_bubble", 32'(a2), 32'(a1 + 1));

    foreach (vt[i]) issue(vt[i].c, vt[i].a, vt[i].b, vt[i].r, vt[i].z, 1'b0, 1, 1'b1, tmp);

    // Longest shift: in_ready stays low while iterating.
    issue(ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 31, 1'b1, tmp);
    for (int k = 0; k < 30; k++) begin
      chk("sra_in_ready_low", {31'b0, in_ready}, 32'h0);
      @(posedge clk); #1;
    end
    issue(ALU_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0, 31, 1'b1, tmp);
    issue(ALU_SLL, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1, 1'b1, tmp);
    issue(ALU_SLL, 32'h0000_0003, 32'd4, 32'h0000_0030, 1'b0, 1'b0, 4, 1'b1, tmp);
    repeat (6) @(posedge clk);
    #1;

    // Backpressure: result held, no new accept until consumer is ready.
    out_ready = 1'b0;
    issue(ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1'b0, 1, 1'b1, ax);
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'h1);
    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b1, 1, 1'b1, ab);
    chk("same_cycle_accept", 32'(ab), 32'(ax + 6));
    issue(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 1, 1'b1, tmp);
    issue(ALU_ADD, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0, 1, 1'b1, tmp);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-shift discards the op.
    issue(ALU_SLL, 32'h0000_0001, 32'd20, 32'h0010_0000, 1'b0, 1'b0, 20, 1'b0, tmp);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_high_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_zero", {31'b0, zero}, 32'h0);
    chk("midrst_illegal", {31'b0, illegal}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      chk("no_stale_out_valid", {31'b0, out_valid}, 32'h0);
      @(posedge clk); #1;
    end
    issue(ALU_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1, 1'b1, tmp);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit ALU control code from the ALU control decoder, plus two operands, and produces a registered result and a zero flag for branch resolution. Logical, add/sub and compare ops complete in one cycle. Shifts run iteratively, one bit per cycle, to save area versus a barrel shifter. Valid/ready handshakes on both sides let the core pipeline stall cleanly while a shift is in flight.

## Interface
- XLEN, 32, operand/result width; shift amount width SHW = $clog2(XLEN)
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand/op presented
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready
- alu_control  in  4  operation code (encodings under Operation)
- op_a  in  XLEN  operand A (shift source)
- op_b  in  XLEN  operand B; shifts use op_b[SHW-1:0]
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  alu_control was not a defined code

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 XOR, 1010 SLL, 1011 SRL, 1100 SRA; all others, including 1111, are illegal.
- Arithmetic is modulo 2^XLEN with overflow ignored. SLT/SLTU yield {XLEN-1 zeros, lt}.
- Illegal code: result = 0, zero = 1, illegal = 1, single-cycle latency. No other side effect.
- FSM states:
  - IDLE: in_ready = 1. On accept of a non-shift op, compute, register outputs, and go to DONE. On accept of a shift with shamt = 0, register op_a and go to DONE. On accept of a shift with shamt ≠ 0, load the working register with op_a and the counter with shamt, then go to SHIFT.
  - SHIFT: in_ready = 0. Each cycle, shift the working register by 1 (SLL: zero in at LSB; SRL: zero in at MSB; SRA: replicate MSB) and decrement the counter. When the counter reaches 1, take the final shift, register the result, and go to DONE.
  - DONE: out_valid = 1, and outputs stay stable. If out_ready, then in_ready = 1 in the same cycle. A simultaneous accept starts the new op and goes to DONE or SHIFT as from IDLE. Accept without a new op goes to IDLE. With no out_ready, stay in DONE.
- zero and illegal are registered together with result. They are never computed combinationally from inputs.
- Inputs are sampled only on accept. op_a, op_b and alu_control may change freely otherwise.

## Timing
- Reset, asserted at any cycle including mid-shift or during DONE, takes effect at the next edge:
  - state goes to IDLE and any in-flight op is discarded with no output;
  - out_valid = 0, result = 0, zero = 0, illegal = 0.
  - in_ready is 0 while rst is high and 1 from the first cycle after release.
- Latency from accept edge to out_valid:
  - 1 cycle for non-shift ops, illegal codes and shamt = 0;
  - shamt cycles for shifts with shamt ≥ 1 (max XLEN-1 = 31).
- Throughput for single-cycle ops with out_ready held high: one op per cycle, back-to-back via DONE→DONE.
- in_ready is combinational from state and out_ready only. It never depends on in_valid, which avoids loops.
- out_valid never drops without a transfer or reset.

## Structure
- alu_pkg holds:
  - localparams for all ten op codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA;
  - a helper function is_shift(code);
  - the FSM state encoding: S_IDLE, S_SHIFT, S_DONE.
- The ALU control decoder imports the same op-code constants.
- One sub-module, alu_shifter_iter, owns the working register, the counter, the 1-bit shift step and a done pulse. alu_exec_unit holds the FSM, the single-cycle datapath and the output registers.

## Test plan
- ADD 0x7FFFFFFF + 1 with out_ready = 1 → out_valid one cycle after accept, result 0x80000000, zero 0. Follow with SUB 5 − 5 back-to-back → result 0, zero 1, no bubble.
- SLT A = 0xFFFFFFFF, B = 1 → 1. SLTU with the same operands → 0.
- SRA A = 0x80000000, shamt 31 → in_ready low for 30 cycles, out_valid at cycle 31, result 0xFFFFFFFF. SRL with the same inputs → 0x00000001. SLL with shamt 0 → A in 1 cycle.
- Backpressure: XOR 0xF0F0F0F0 ^ 0xFFFF0000 with out_ready = 0 for 5 cycles → result 0x0F0FF0F0 held stable and in_ready = 0 throughout. Raising out_ready lets the next op be accepted in the same cycle.
- Code 1111 → illegal = 1, result 0, zero 1, after 1 cycle. Code 0011 behaves identically.
- Assert rst during an SLL with shamt 20 at cycle 7 → next cycle state IDLE with all outputs 0, no stale out_valid afterwards, and a fresh ADD after release completes normally.
